// File: rtl/lcd_frame_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_frame_arbiter_pkg: shared constants and FSM states for the frame |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lcd_frame_arbiter_pkg;

  localparam int         LCD_LINE_LEN   = 16;
  localparam logic [7:0] LCD_LINE2_BASE = 8'h40;
  localparam logic [7:0] ASCII_SPACE    = 8'h20;
  localparam int         FRAME_CELLS    = 2 * LCD_LINE_LEN;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } frame_state_e;

endpackage
`default_nettype wire

// File: rtl/lcd_frame_arbiter_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_frame_arbiter_rr_arb2: 2-way round-robin arbiter, one-hot grant  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lcd_frame_arbiter_rr_arb2 #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic ptr_q;

  // ptr_q names the client that wins the next contended cycle.
  assign gnt0_o = en_i & req0_i & (~req1_i | ~ptr_q);
  assign gnt1_o = en_i & req1_i & (~req0_i |  ptr_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= RR_INIT;
    end else if (gnt0_o) begin
      ptr_q <= 1'b1;
    end else if (gnt1_o) begin
      ptr_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_frame_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_frame_arbiter: 2x16 LCD character frame, shared by two writers   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lcd_frame_arbiter
  import lcd_frame_arbiter_pkg::*;
#(
  parameter logic [7:0] FILL_CHAR = ASCII_SPACE,
  parameter logic       RR_INIT   = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CLR,
  input  logic       REQ0,
  input  logic [4:0] ADDR0,
  input  logic [7:0] DATA0,
  output logic       GNT0,
  input  logic       REQ1,
  input  logic [4:0] ADDR1,
  input  logic [7:0] DATA1,
  output logic       GNT1,
  input  logic [7:0] INDEX,
  output logic [7:0] CHAR,
  output logic       BUSY
);

  localparam int                CNT_W    = $clog2(FRAME_CELLS);
  localparam logic [CNT_W-1:0]  CLR_LAST = CNT_W'(FRAME_CELLS - 1);

  frame_state_e     state_q;
  logic [CNT_W-1:0] clr_cnt_q;
  logic [7:0]       frame_q [FRAME_CELLS];
  logic             arb_en;
  logic             line1_hit;
  logic             line2_hit;
  logic [4:0]       rd_addr;

  always_ff @(posedge CLK) begin
    if (!RST_N || CLR) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      if (clr_cnt_q == CLR_LAST) begin
        state_q <= ST_IDLE;
      end else begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end
    end
  end

  assign BUSY   = (state_q == ST_CLEAR);
  assign arb_en = RST_N & ~CLR & (state_q == ST_IDLE);

  lcd_frame_arbiter_rr_arb2 #(
    .RR_INIT (RR_INIT)
  ) u_arb (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .en_i   (arb_en),
    .req0_i (REQ0),
    .req1_i (REQ1),
    .gnt0_o (GNT0),
    .gnt1_o (GNT1)
  );

  // Single write port with no reset so the frame maps onto a RAM.
  always_ff @(posedge CLK) begin
    if (state_q == ST_CLEAR) begin
      frame_q[clr_cnt_q] <= FILL_CHAR;
    end else if (GNT0) begin
      frame_q[ADDR0] <= DATA0;
    end else if (GNT1) begin
      frame_q[ADDR1] <= DATA1;
    end
  end

  assign line1_hit = (INDEX[7:4] == 4'h0);
  assign line2_hit = (INDEX[7:4] == LCD_LINE2_BASE[7:4]);
  assign rd_addr   = {line2_hit, INDEX[3:0]};
  assign CHAR      = (BUSY || !(line1_hit || line2_hit)) ? FILL_CHAR : frame_q[rd_addr];

endmodule
`default_nettype wire
